// File: rtl/role_arb_pkg.sv
// Shared types for the two-master memory-port arbiter.
// Imported by the arbiter top and its round-robin picker.
package role_arb_pkg;

    localparam int NUM_MASTERS = 2;

    typedef logic mst_idx_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ADDR,
        RD_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_XFER,
        WR_RESP
    } wr_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on contention the master that did
// not win last time is chosen.
module rr_arb2
    import role_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  mst_idx_t               last,
    output mst_idx_t               gnt,
    output logic                   any
);

    always_comb begin
        gnt = 1'b0;
        unique case (req)
            2'b11:   gnt = ~last;
            2'b10:   gnt = 1'b1;
            default: gnt = 1'b0;
        endcase
    end

    assign any = |req;

endmodule

// File: rtl/role_mem_arbiter.sv
// Shares the role's single AXI4 memory master between two requesters,
// with independent round-robin read and write paths, one burst each.
module role_mem_arbiter
    import role_arb_pkg::*;
#(
    parameter int ADDR_W = 36,
    parameter int DATA_W = 256
) (
    input  logic                aclk,
    input  logic                aresetn,
    // s0 read
    input  logic [ADDR_W-1:0]   s0_axi_araddr,
    input  logic [7:0]          s0_axi_arlen,
    input  logic [2:0]          s0_axi_arsize,
    input  logic [1:0]          s0_axi_arburst,
    input  logic                s0_axi_arlock,
    input  logic [3:0]          s0_axi_arcache,
    input  logic [2:0]          s0_axi_arprot,
    input  logic [3:0]          s0_axi_arqos,
    input  logic                s0_axi_arvalid,
    output logic                s0_axi_arready,
    output logic [DATA_W-1:0]   s0_axi_rdata,
    output logic [1:0]          s0_axi_rresp,
    output logic                s0_axi_rlast,
    output logic                s0_axi_rvalid,
    input  logic                s0_axi_rready,
    // s0 write
    input  logic [ADDR_W-1:0]   s0_axi_awaddr,
    input  logic [7:0]          s0_axi_awlen,
    input  logic [2:0]          s0_axi_awsize,
    input  logic [1:0]          s0_axi_awburst,
    input  logic                s0_axi_awlock,
    input  logic [3:0]          s0_axi_awcache,
    input  logic [2:0]          s0_axi_awprot,
    input  logic [3:0]          s0_axi_awqos,
    input  logic                s0_axi_awvalid,
    output logic                s0_axi_awready,
    input  logic [DATA_W-1:0]   s0_axi_wdata,
    input  logic [DATA_W/8-1:0] s0_axi_wstrb,
    input  logic                s0_axi_wlast,
    input  logic                s0_axi_wvalid,
    output logic                s0_axi_wready,
    output logic [1:0]          s0_axi_bresp,
    output logic                s0_axi_bvalid,
    input  logic                s0_axi_bready,
    // s1 read
    input  logic [ADDR_W-1:0]   s1_axi_araddr,
    input  logic [7:0]          s1_axi_arlen,
    input  logic [2:0]          s1_axi_arsize,
    input  logic [1:0]          s1_axi_arburst,
    input  logic                s1_axi_arlock,
    input  logic [3:0]          s1_axi_arcache,
    input  logic [2:0]          s1_axi_arprot,
    input  logic [3:0]          s1_axi_arqos,
    input  logic                s1_axi_arvalid,
    output logic                s1_axi_arready,
    output logic [DATA_W-1:0]   s1_axi_rdata,
    output logic [1:0]          s1_axi_rresp,
    output logic                s1_axi_rlast,
    output logic                s1_axi_rvalid,
    input  logic                s1_axi_rready,
    // s1 write
    input  logic [ADDR_W-1:0]   s1_axi_awaddr,
    input  logic [7:0]          s1_axi_awlen,
    input  logic [2:0]          s1_axi_awsize,
    input  logic [1:0]          s1_axi_awburst,
    input  logic                s1_axi_awlock,
    input  logic [3:0]          s1_axi_awcache,
    input  logic [2:0]          s1_axi_awprot,
    input  logic [3:0]          s1_axi_awqos,
    input  logic                s1_axi_awvalid,
    output logic                s1_axi_awready,
    input  logic [DATA_W-1:0]   s1_axi_wdata,
    input  logic [DATA_W/8-1:0] s1_axi_wstrb,
    input  logic                s1_axi_wlast,
    input  logic                s1_axi_wvalid,
    output logic                s1_axi_wready,
    output logic [1:0]          s1_axi_bresp,
    output logic                s1_axi_bvalid,
    input  logic                s1_axi_bready,
    // memory master
    output logic [ADDR_W-1:0]   m_axi_mem_araddr,
    output logic [7:0]          m_axi_mem_arlen,
    output logic [2:0]          m_axi_mem_arsize,
    output logic [1:0]          m_axi_mem_arburst,
    output logic                m_axi_mem_arlock,
    output logic [3:0]          m_axi_mem_arcache,
    output logic [2:0]          m_axi_mem_arprot,
    output logic [3:0]          m_axi_mem_arqos,
    output logic                m_axi_mem_arvalid,
    input  logic                m_axi_mem_arready,
    input  logic [DATA_W-1:0]   m_axi_mem_rdata,
    input  logic [1:0]          m_axi_mem_rresp,
    input  logic                m_axi_mem_rlast,
    input  logic                m_axi_mem_rvalid,
    output logic                m_axi_mem_rready,
    output logic [ADDR_W-1:0]   m_axi_mem_awaddr,
    output logic [7:0]          m_axi_mem_awlen,
    output logic [2:0]          m_axi_mem_awsize,
    output logic [1:0]          m_axi_mem_awburst,
    output logic                m_axi_mem_awlock,
    output logic [3:0]          m_axi_mem_awcache,
    output logic [2:0]          m_axi_mem_awprot,
    output logic [3:0]          m_axi_mem_awqos,
    output logic                m_axi_mem_awvalid,
    input  logic                m_axi_mem_awready,
    output logic [DATA_W-1:0]   m_axi_mem_wdata,
    output logic [DATA_W/8-1:0] m_axi_mem_wstrb,
    output logic                m_axi_mem_wlast,
    output logic                m_axi_mem_wvalid,
    input  logic                m_axi_mem_wready,
    input  logic [1:0]          m_axi_mem_bresp,
    input  logic                m_axi_mem_bvalid,
    output logic                m_axi_mem_bready,
    // status
    output logic                rd_busy,
    output logic                wr_busy
);

    rd_state_t rd_st, rd_nxt;
    wr_state_t wr_st, wr_nxt;
    mst_idx_t  rd_gnt, rd_last, rd_pick;
    mst_idx_t  wr_gnt, wr_last, wr_pick;
    logic      rd_any, wr_any;
    logic      aw_done, w_done;
    logic      rd_a, rd_d, wr_x, wr_r;
    logic      ar_hs, rd_done, aw_hs, wl_hs, b_hs;

    rr_arb2 u_rd_arb (
        .req  ({s1_axi_arvalid, s0_axi_arvalid}),
        .last (rd_last),
        .gnt  (rd_pick),
        .any  (rd_any)
    );

    rr_arb2 u_wr_arb (
        .req  ({s1_axi_awvalid, s0_axi_awvalid}),
        .last (wr_last),
        .gnt  (wr_pick),
        .any  (wr_any)
    );

    assign rd_a = (rd_st == RD_ADDR);
    assign rd_d = (rd_st == RD_DATA);
    assign wr_x = (wr_st == WR_XFER);
    assign wr_r = (wr_st == WR_RESP);

    assign rd_busy = (rd_st != RD_IDLE);
    assign wr_busy = (wr_st != WR_IDLE);

    // Read address: fields follow the grant, valid only in ADDR
    assign m_axi_mem_araddr  = rd_gnt ? s1_axi_araddr  : s0_axi_araddr;
    assign m_axi_mem_arlen   = rd_gnt ? s1_axi_arlen   : s0_axi_arlen;
    assign m_axi_mem_arsize  = rd_gnt ? s1_axi_arsize  : s0_axi_arsize;
    assign m_axi_mem_arburst = rd_gnt ? s1_axi_arburst : s0_axi_arburst;
    assign m_axi_mem_arlock  = rd_gnt ? s1_axi_arlock  : s0_axi_arlock;
    assign m_axi_mem_arcache = rd_gnt ? s1_axi_arcache : s0_axi_arcache;
    assign m_axi_mem_arprot  = rd_gnt ? s1_axi_arprot  : s0_axi_arprot;
    assign m_axi_mem_arqos   = rd_gnt ? s1_axi_arqos   : s0_axi_arqos;
    assign m_axi_mem_arvalid = rd_a &
        (rd_gnt ? s1_axi_arvalid : s0_axi_arvalid);
    assign s0_axi_arready = rd_a & ~rd_gnt & m_axi_mem_arready;
    assign s1_axi_arready = rd_a &  rd_gnt & m_axi_mem_arready;

    assign s0_axi_rdata  = m_axi_mem_rdata;
    assign s1_axi_rdata  = m_axi_mem_rdata;
    assign s0_axi_rresp  = m_axi_mem_rresp;
    assign s1_axi_rresp  = m_axi_mem_rresp;
    assign s0_axi_rlast  = m_axi_mem_rlast;
    assign s1_axi_rlast  = m_axi_mem_rlast;
    assign s0_axi_rvalid = rd_d & ~rd_gnt & m_axi_mem_rvalid;
    assign s1_axi_rvalid = rd_d &  rd_gnt & m_axi_mem_rvalid;
    assign m_axi_mem_rready = rd_d &
        (rd_gnt ? s1_axi_rready : s0_axi_rready);

    assign ar_hs   = m_axi_mem_arvalid & m_axi_mem_arready;
    assign rd_done = m_axi_mem_rvalid & m_axi_mem_rready & m_axi_mem_rlast;

    always_comb begin
        rd_nxt = rd_st;
        unique case (rd_st)
            RD_IDLE: if (rd_any) rd_nxt = RD_ADDR;
            RD_ADDR: if (ar_hs) rd_nxt = RD_DATA;
            RD_DATA: if (rd_done) rd_nxt = RD_IDLE;
            default: rd_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_st   <= RD_IDLE;
            rd_gnt  <= 1'b0;
            rd_last <= 1'b1;
        end else begin
            rd_st <= rd_nxt;
            if (rd_st == RD_IDLE && rd_any) rd_gnt <= rd_pick;
            if (rd_d && rd_done) rd_last <= rd_gnt;
        end
    end

    // Write address and data; each is masked once its part is done
    assign m_axi_mem_awaddr  = wr_gnt ? s1_axi_awaddr  : s0_axi_awaddr;
    assign m_axi_mem_awlen   = wr_gnt ? s1_axi_awlen   : s0_axi_awlen;
    assign m_axi_mem_awsize  = wr_gnt ? s1_axi_awsize  : s0_axi_awsize;
    assign m_axi_mem_awburst = wr_gnt ? s1_axi_awburst : s0_axi_awburst;
    assign m_axi_mem_awlock  = wr_gnt ? s1_axi_awlock  : s0_axi_awlock;
    assign m_axi_mem_awcache = wr_gnt ? s1_axi_awcache : s0_axi_awcache;
    assign m_axi_mem_awprot  = wr_gnt ? s1_axi_awprot  : s0_axi_awprot;
    assign m_axi_mem_awqos   = wr_gnt ? s1_axi_awqos   : s0_axi_awqos;
    assign m_axi_mem_awvalid = wr_x & ~aw_done &
        (wr_gnt ? s1_axi_awvalid : s0_axi_awvalid);
    assign s0_axi_awready = wr_x & ~aw_done & ~wr_gnt & m_axi_mem_awready;
    assign s1_axi_awready = wr_x & ~aw_done &  wr_gnt & m_axi_mem_awready;

    assign m_axi_mem_wdata  = wr_gnt ? s1_axi_wdata : s0_axi_wdata;
    assign m_axi_mem_wstrb  = wr_gnt ? s1_axi_wstrb : s0_axi_wstrb;
    assign m_axi_mem_wlast  = wr_gnt ? s1_axi_wlast : s0_axi_wlast;
    assign m_axi_mem_wvalid = wr_x & ~w_done &
        (wr_gnt ? s1_axi_wvalid : s0_axi_wvalid);
    assign s0_axi_wready = wr_x & ~w_done & ~wr_gnt & m_axi_mem_wready;
    assign s1_axi_wready = wr_x & ~w_done &  wr_gnt & m_axi_mem_wready;

    assign s0_axi_bresp  = m_axi_mem_bresp;
    assign s1_axi_bresp  = m_axi_mem_bresp;
    assign s0_axi_bvalid = wr_r & ~wr_gnt & m_axi_mem_bvalid;
    assign s1_axi_bvalid = wr_r &  wr_gnt & m_axi_mem_bvalid;
    assign m_axi_mem_bready = wr_r &
        (wr_gnt ? s1_axi_bready : s0_axi_bready);

    assign aw_hs = m_axi_mem_awvalid & m_axi_mem_awready;
    assign wl_hs = m_axi_mem_wvalid & m_axi_mem_wready & m_axi_mem_wlast;
    assign b_hs  = m_axi_mem_bvalid & m_axi_mem_bready;

    always_comb begin
        wr_nxt = wr_st;
        unique case (wr_st)
            WR_IDLE: if (wr_any) wr_nxt = WR_XFER;
            WR_XFER: if ((aw_done | aw_hs) & (w_done | wl_hs))
                         wr_nxt = WR_RESP;
            WR_RESP: if (b_hs) wr_nxt = WR_IDLE;
            default: wr_nxt = WR_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_st   <= WR_IDLE;
            wr_gnt  <= 1'b0;
            wr_last <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            wr_st <= wr_nxt;
            if (wr_st == WR_IDLE) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                if (wr_any) wr_gnt <= wr_pick;
            end
            if (wr_x) begin
                aw_done <= aw_done | aw_hs;
                w_done  <= w_done | wl_hs;
            end
            if (wr_r && b_hs) wr_last <= wr_gnt;
        end
    end

endmodule

// File: tb/tb_role_mem_arbiter.sv
// Directed self-checking bench for role_mem_arbiter: reset, arbitration,
// write ordering, concurrency, error responses and mid-burst reset.
module tb_role_mem_arbiter;

    localparam int ADDR_W = 36;
    localparam int DATA_W = 256;
    localparam int SW = DATA_W / 8;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;

    logic [ADDR_W-1:0] s0_axi_araddr = '0, s1_axi_araddr = '0;
    logic [7:0] s0_axi_arlen = '0, s1_axi_arlen = '0;
    logic [2:0] s0_axi_arsize = '0, s1_axi_arsize = '0;
    logic [1:0] s0_axi_arburst = '0, s1_axi_arburst = '0;
    logic s0_axi_arlock = 1'b0, s1_axi_arlock = 1'b0;
    logic [3:0] s0_axi_arcache = '0, s1_axi_arcache = '0;
    logic [2:0] s0_axi_arprot = '0, s1_axi_arprot = '0;
    logic [3:0] s0_axi_arqos = '0, s1_axi_arqos = '0;
    logic s0_axi_arvalid = 1'b0, s1_axi_arvalid = 1'b0;
    logic s0_axi_arready, s1_axi_arready;
    logic [DATA_W-1:0] s0_axi_rdata, s1_axi_rdata;
    logic [1:0] s0_axi_rresp, s1_axi_rresp;
    logic s0_axi_rlast, s1_axi_rlast, s0_axi_rvalid, s1_axi_rvalid;
    logic s0_axi_rready = 1'b0, s1_axi_rready = 1'b0;
    logic [ADDR_W-1:0] s0_axi_awaddr = '0, s1_axi_awaddr = '0;
    logic [7:0] s0_axi_awlen = '0, s1_axi_awlen = '0;
    logic [2:0] s0_axi_awsize = '0, s1_axi_awsize = '0;
    logic [1:0] s0_axi_awburst = '0, s1_axi_awburst = '0;
    logic s0_axi_awlock = 1'b0, s1_axi_awlock = 1'b0;
    logic [3:0] s0_axi_awcache = '0, s1_axi_awcache = '0;
    logic [2:0] s0_axi_awprot = '0, s1_axi_awprot = '0;
    logic [3:0] s0_axi_awqos = '0, s1_axi_awqos = '0;
    logic s0_axi_awvalid = 1'b0, s1_axi_awvalid = 1'b0;
    logic s0_axi_awready, s1_axi_awready;
    logic [DATA_W-1:0] s0_axi_wdata = '0, s1_axi_wdata = '0;
    logic [SW-1:0] s0_axi_wstrb = '1, s1_axi_wstrb = '1;
    logic s0_axi_wlast = 1'b0, s1_axi_wlast = 1'b0;
    logic s0_axi_wvalid = 1'b0, s1_axi_wvalid = 1'b0;
    logic s0_axi_wready, s1_axi_wready;
    logic [1:0] s0_axi_bresp, s1_axi_bresp;
    logic s0_axi_bvalid, s1_axi_bvalid;
    logic s0_axi_bready = 1'b0, s1_axi_bready = 1'b0;

    logic [ADDR_W-1:0] m_axi_mem_araddr, m_axi_mem_awaddr;
    logic [7:0] m_axi_mem_arlen, m_axi_mem_awlen;
    logic [2:0] m_axi_mem_arsize, m_axi_mem_awsize;
    logic [1:0] m_axi_mem_arburst, m_axi_mem_awburst;
    logic m_axi_mem_arlock, m_axi_mem_awlock;
    logic [3:0] m_axi_mem_arcache, m_axi_mem_awcache;
    logic [2:0] m_axi_mem_arprot, m_axi_mem_awprot;
    logic [3:0] m_axi_mem_arqos, m_axi_mem_awqos;
    logic m_axi_mem_arvalid, m_axi_mem_awvalid;
    logic m_axi_mem_arready = 1'b0, m_axi_mem_awready = 1'b0;
    logic [DATA_W-1:0] m_axi_mem_rdata = '0;
    logic [1:0] m_axi_mem_rresp = '0;
    logic m_axi_mem_rlast = 1'b0, m_axi_mem_rvalid = 1'b0;
    logic m_axi_mem_rready;
    logic [DATA_W-1:0] m_axi_mem_wdata;
    logic [SW-1:0] m_axi_mem_wstrb;
    logic m_axi_mem_wlast, m_axi_mem_wvalid;
    logic m_axi_mem_wready = 1'b0;
    logic [1:0] m_axi_mem_bresp = '0;
    logic m_axi_mem_bvalid = 1'b0;
    logic m_axi_mem_bready;
    logic rd_busy, wr_busy;

    int checks = 0;
    int errors = 0;

    role_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0_axi_araddr(s0_axi_araddr), .s0_axi_arlen(s0_axi_arlen),
        .s0_axi_arsize(s0_axi_arsize), .s0_axi_arburst(s0_axi_arburst),
        .s0_axi_arlock(s0_axi_arlock), .s0_axi_arcache(s0_axi_arcache),
        .s0_axi_arprot(s0_axi_arprot), .s0_axi_arqos(s0_axi_arqos),
        .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready),
        .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp),
        .s0_axi_rlast(s0_axi_rlast), .s0_axi_rvalid(s0_axi_rvalid),
        .s0_axi_rready(s0_axi_rready),
        .s0_axi_awaddr(s0_axi_awaddr), .s0_axi_awlen(s0_axi_awlen),
        .s0_axi_awsize(s0_axi_awsize), .s0_axi_awburst(s0_axi_awburst),
        .s0_axi_awlock(s0_axi_awlock), .s0_axi_awcache(s0_axi_awcache),
        .s0_axi_awprot(s0_axi_awprot), .s0_axi_awqos(s0_axi_awqos),
        .s0_axi_awvalid(s0_axi_awvalid), .s0_axi_awready(s0_axi_awready),
        .s0_axi_wdata(s0_axi_wdata), .s0_axi_wstrb(s0_axi_wstrb),
        .s0_axi_wlast(s0_axi_wlast), .s0_axi_wvalid(s0_axi_wvalid),
        .s0_axi_wready(s0_axi_wready),
        .s0_axi_bresp(s0_axi_bresp), .s0_axi_bvalid(s0_axi_bvalid),
        .s0_axi_bready(s0_axi_bready),
        .s1_axi_araddr(s1_axi_araddr), .s1_axi_arlen(s1_axi_arlen),
        .s1_axi_arsize(s1_axi_arsize), .s1_axi_arburst(s1_axi_arburst),
        .s1_axi_arlock(s1_axi_arlock), .s1_axi_arcache(s1_axi_arcache),
        .s1_axi_arprot(s1_axi_arprot), .s1_axi_arqos(s1_axi_arqos),
        .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arready(s1_axi_arready),
        .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp),
        .s1_axi_rlast(s1_axi_rlast), .s1_axi_rvalid(s1_axi_rvalid),
        .s1_axi_rready(s1_axi_rready),
        .s1_axi_awaddr(s1_axi_awaddr), .s1_axi_awlen(s1_axi_awlen),
        .s1_axi_awsize(s1_axi_awsize), .s1_axi_awburst(s1_axi_awburst),
        .s1_axi_awlock(s1_axi_awlock), .s1_axi_awcache(s1_axi_awcache),
        .s1_axi_awprot(s1_axi_awprot), .s1_axi_awqos(s1_axi_awqos),
        .s1_axi_awvalid(s1_axi_awvalid), .s1_axi_awready(s1_axi_awready),
        .s1_axi_wdata(s1_axi_wdata), .s1_axi_wstrb(s1_axi_wstrb),
        .s1_axi_wlast(s1_axi_wlast), .s1_axi_wvalid(s1_axi_wvalid),
        .s1_axi_wready(s1_axi_wready),
        .s1_axi_bresp(s1_axi_bresp), .s1_axi_bvalid(s1_axi_bvalid),
        .s1_axi_bready(s1_axi_bready),
        .m_axi_mem_araddr(m_axi_mem_araddr),
        .m_axi_mem_arlen(m_axi_mem_arlen),
        .m_axi_mem_arsize(m_axi_mem_arsize),
        .m_axi_mem_arburst(m_axi_mem_arburst),
        .m_axi_mem_arlock(m_axi_mem_arlock),
        .m_axi_mem_arcache(m_axi_mem_arcache),
        .m_axi_mem_arprot(m_axi_mem_arprot),
        .m_axi_mem_arqos(m_axi_mem_arqos),
        .m_axi_mem_arvalid(m_axi_mem_arvalid),
        .m_axi_mem_arready(m_axi_mem_arready),
        .m_axi_mem_rdata(m_axi_mem_rdata),
        .m_axi_mem_rresp(m_axi_mem_rresp),
        .m_axi_mem_rlast(m_axi_mem_rlast),
        .m_axi_mem_rvalid(m_axi_mem_rvalid),
        .m_axi_mem_rready(m_axi_mem_rready),
        .m_axi_mem_awaddr(m_axi_mem_awaddr),
        .m_axi_mem_awlen(m_axi_mem_awlen),
        .m_axi_mem_awsize(m_axi_mem_awsize),
        .m_axi_mem_awburst(m_axi_mem_awburst),
        .m_axi_mem_awlock(m_axi_mem_awlock),
        .m_axi_mem_awcache(m_axi_mem_awcache),
        .m_axi_mem_awprot(m_axi_mem_awprot),
        .m_axi_mem_awqos(m_axi_mem_awqos),
        .m_axi_mem_awvalid(m_axi_mem_awvalid),
        .m_axi_mem_awready(m_axi_mem_awready),
        .m_axi_mem_wdata(m_axi_mem_wdata),
        .m_axi_mem_wstrb(m_axi_mem_wstrb),
        .m_axi_mem_wlast(m_axi_mem_wlast),
        .m_axi_mem_wvalid(m_axi_mem_wvalid),
        .m_axi_mem_wready(m_axi_mem_wready),
        .m_axi_mem_bresp(m_axi_mem_bresp),
        .m_axi_mem_bvalid(m_axi_mem_bvalid),
        .m_axi_mem_bready(m_axi_mem_bready),
        .rd_busy(rd_busy), .wr_busy(wr_busy)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    initial begin
        int c0, c1, e;
        c0 = 0;
        c1 = 0;
        // Reset: requests and responses present but everything gated
        repeat (2) tick();
        s0_axi_arvalid = 1'b1;
        m_axi_mem_rvalid = 1'b1;
        #1;
        chk("rst_m_arvalid", 64'(m_axi_mem_arvalid), 64'(0));
        chk("rst_m_awvalid", 64'(m_axi_mem_awvalid), 64'(0));
        chk("rst_m_wvalid", 64'(m_axi_mem_wvalid), 64'(0));
        chk("rst_m_rready", 64'(m_axi_mem_rready), 64'(0));
        chk("rst_m_bready", 64'(m_axi_mem_bready), 64'(0));
        chk("rst_s0_rvalid", 64'(s0_axi_rvalid), 64'(0));
        chk("rst_s0_arready", 64'(s0_axi_arready), 64'(0));
        chk("rst_busy", 64'({rd_busy, wr_busy}), 64'(0));
        s0_axi_arvalid = 1'b0;
        m_axi_mem_rvalid = 1'b0;
        aresetn = 1'b1;
        tick();

        // Single s0 read burst, 4 beats
        s0_axi_araddr = 36'h1_0000_0000;
        s0_axi_arlen = 8'd3;
        s0_axi_arvalid = 1'b1;
        m_axi_mem_arready = 1'b1;
        #1;
        chk("t1_idle_arvalid", 64'(m_axi_mem_arvalid), 64'(0));
        tick();
        #1;
        chk("t1_m_arvalid", 64'(m_axi_mem_arvalid), 64'(1));
        chk("t1_m_araddr", 64'(m_axi_mem_araddr), 64'h1_0000_0000);
        chk("t1_m_arlen", 64'(m_axi_mem_arlen), 64'(3));
        chk("t1_arready", 64'({s1_axi_arready, s0_axi_arready}), 64'(1));
        chk("t1_rd_busy", 64'(rd_busy), 64'(1));
        tick();
        s0_axi_arvalid = 1'b0;
        s0_axi_rready = 1'b1;
        s1_axi_rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_axi_mem_rvalid = 1'b1;
            m_axi_mem_rdata = {4{64'(176 + i)}};
            m_axi_mem_rlast = (i == 3);
            m_axi_mem_rresp = (i == 3) ? 2'b11 : 2'b00;
            #1;
            chk("t1_m_arvalid_dat", 64'(m_axi_mem_arvalid), 64'(0));
            chk("t1_s0_rvalid", 64'(s0_axi_rvalid), 64'(1));
            chk("t1_s1_rvalid", 64'(s1_axi_rvalid), 64'(0));
            chk("t1_s0_rdata", s0_axi_rdata[63:0], 64'(176 + i));
            chk("t1_s0_rlast", 64'(s0_axi_rlast), 64'(i == 3));
            chk("t1_m_rready", 64'(m_axi_mem_rready), 64'(1));
            if (i == 3) chk("t1_rresp", 64'(s0_axi_rresp), 64'(3));
            tick();
        end
        m_axi_mem_rvalid = 1'b0;
        m_axi_mem_rlast = 1'b0;
        m_axi_mem_rresp = 2'b00;
        #1;
        chk("t1_idle_after", 64'(rd_busy), 64'(0));

        // Fresh reset, then three back-to-back bursts from each master
        aresetn = 1'b0;
        #1;
        aresetn = 1'b1;
        s0_axi_araddr = 36'hA00;
        s1_axi_araddr = 36'hB00;
        s0_axi_arlen = 8'd0;
        s1_axi_arlen = 8'd0;
        s0_axi_arvalid = 1'b1;
        s1_axi_arvalid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            e = k % 2;
            tick();
            #1;
            chk("t2_grant", 64'({s1_axi_arready, s0_axi_arready}),
                64'(e ? 2 : 1));
            chk("t2_addr", 64'(m_axi_mem_araddr),
                e ? 64'(36'hB00 + 36'(c1)) : 64'(36'hA00 + 36'(c0)));
            tick();
            if (e == 0) begin
                c0++;
                s0_axi_araddr = 36'hA00 + 36'(c0);
                if (c0 == 3) s0_axi_arvalid = 1'b0;
            end else begin
                c1++;
                s1_axi_araddr = 36'hB00 + 36'(c1);
                if (c1 == 3) s1_axi_arvalid = 1'b0;
            end
            m_axi_mem_rvalid = 1'b1;
            m_axi_mem_rlast = 1'b1;
            #1;
            chk("t2_route", 64'({s1_axi_rvalid, s0_axi_rvalid}),
                64'(e ? 2 : 1));
            tick();
            m_axi_mem_rvalid = 1'b0;
            m_axi_mem_rlast = 1'b0;
        end

        // s1 write of 8 beats, W accepted downstream ahead of AW
        s1_axi_awaddr = 36'h2_0000_0040;
        s1_axi_awlen = 8'd7;
        s1_axi_awvalid = 1'b1;
        s1_axi_wvalid = 1'b1;
        s1_axi_bready = 1'b1;
        m_axi_mem_wready = 1'b1;
        m_axi_mem_awready = 1'b0;
        #1;
        chk("t3_idle_wvalid", 64'(m_axi_mem_wvalid), 64'(0));
        tick();
        for (int b = 0; b < 8; b++) begin
            s1_axi_wdata = {4{64'(192 + b)}};
            s1_axi_wlast = (b == 7);
            m_axi_mem_awready = (b == 2);
            #1;
            chk("t3_m_wvalid", 64'(m_axi_mem_wvalid), 64'(1));
            chk("t3_m_wdata", m_axi_mem_wdata[63:0], 64'(192 + b));
            chk("t3_m_wlast", 64'(m_axi_mem_wlast), 64'(b == 7));
            chk("t3_wready", 64'({s1_axi_wready, s0_axi_wready}), 64'(2));
            chk("t3_m_awvalid", 64'(m_axi_mem_awvalid), 64'(b <= 2));
            chk("t3_wr_busy", 64'(wr_busy), 64'(1));
            tick();
        end
        m_axi_mem_awready = 1'b0;
        #1;
        chk("t3_resp_wmask", 64'(m_axi_mem_wvalid), 64'(0));
        chk("t3_resp_awmask", 64'(m_axi_mem_awvalid), 64'(0));
        s1_axi_awvalid = 1'b0;
        s1_axi_wvalid = 1'b0;
        s1_axi_wlast = 1'b0;
        s0_axi_bready = 1'b1;
        m_axi_mem_bvalid = 1'b1;
        m_axi_mem_bresp = 2'b00;
        #1;
        chk("t3_bvalid", 64'({s1_axi_bvalid, s0_axi_bvalid}), 64'(2));
        chk("t3_bresp", 64'(s1_axi_bresp), 64'(0));
        chk("t3_m_bready", 64'(m_axi_mem_bready), 64'(1));
        tick();
        m_axi_mem_bvalid = 1'b0;
        #1;
        chk("t3_wr_idle", 64'(wr_busy), 64'(0));

        // Concurrent s0 read and s1 write, downstream always ready
        s0_axi_araddr = 36'h3_0000_0000;
        s0_axi_arvalid = 1'b1;
        s1_axi_awlen = 8'd0;
        s1_axi_awvalid = 1'b1;
        s1_axi_wvalid = 1'b1;
        s1_axi_wlast = 1'b1;
        m_axi_mem_arready = 1'b1;
        m_axi_mem_awready = 1'b1;
        tick();
        #1;
        chk("t4_busy", 64'({rd_busy, wr_busy}), 64'(3));
        chk("t4_valids", 64'({m_axi_mem_arvalid, m_axi_mem_awvalid,
            m_axi_mem_wvalid}), 64'(7));
        chk("t4_arready", 64'({s1_axi_arready, s0_axi_arready}), 64'(1));
        chk("t4_awready", 64'({s1_axi_awready, s0_axi_awready}), 64'(2));
        chk("t4_wready", 64'({s1_axi_wready, s0_axi_wready}), 64'(2));
        tick();
        s0_axi_arvalid = 1'b0;
        s1_axi_awvalid = 1'b0;
        s1_axi_wvalid = 1'b0;
        s1_axi_wlast = 1'b0;
        m_axi_mem_rvalid = 1'b1;
        m_axi_mem_rlast = 1'b1;
        m_axi_mem_bvalid = 1'b1;
        #1;
        chk("t4_rvalid", 64'({s1_axi_rvalid, s0_axi_rvalid}), 64'(1));
        chk("t4_bvalid", 64'({s1_axi_bvalid, s0_axi_bvalid}), 64'(2));
        tick();
        m_axi_mem_rvalid = 1'b0;
        m_axi_mem_rlast = 1'b0;
        m_axi_mem_bvalid = 1'b0;
        #1;
        chk("t4_idle", 64'({rd_busy, wr_busy}), 64'(0));

        // s0 write answered with SLVERR
        s0_axi_awaddr = 36'h4_0000_0000;
        s0_axi_awvalid = 1'b1;
        s0_axi_wvalid = 1'b1;
        s0_axi_wlast = 1'b1;
        tick();
        #1;
        chk("t5_awready", 64'({s1_axi_awready, s0_axi_awready}), 64'(1));
        tick();
        s0_axi_awvalid = 1'b0;
        s0_axi_wvalid = 1'b0;
        s0_axi_wlast = 1'b0;
        m_axi_mem_bvalid = 1'b1;
        m_axi_mem_bresp = 2'b10;
        #1;
        chk("t5_bresp", 64'(s0_axi_bresp), 64'(2));
        chk("t5_bvalid", 64'({s1_axi_bvalid, s0_axi_bvalid}), 64'(1));
        tick();
        m_axi_mem_bvalid = 1'b0;
        m_axi_mem_bresp = 2'b00;
        #1;
        chk("t5_wr_idle", 64'(wr_busy), 64'(0));

        // Reset in the middle of beat 2 of a 4-beat s0 read
        s0_axi_arlen = 8'd3;
        s0_axi_arvalid = 1'b1;
        tick();
        tick();
        s0_axi_arvalid = 1'b0;
        m_axi_mem_rvalid = 1'b1;
        tick();
        #1;
        chk("t6_beat2", 64'(s0_axi_rvalid), 64'(1));
        aresetn = 1'b0;
        #1;
        chk("t6_rvalid", 64'(s0_axi_rvalid), 64'(0));
        chk("t6_rready", 64'(m_axi_mem_rready), 64'(0));
        chk("t6_arvalid", 64'(m_axi_mem_arvalid), 64'(0));
        chk("t6_rd_busy", 64'(rd_busy), 64'(0));
        m_axi_mem_rvalid = 1'b0;
        aresetn = 1'b1;
        s0_axi_arvalid = 1'b1;
        s1_axi_arvalid = 1'b1;
        tick();
        #1;
        chk("t6_regrant", 64'({s1_axi_arready, s0_axi_arready}), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
